// File: rtl/manchester_led_encoder_pkg.sv
// Shared definitions for the LightIO Manchester LED encoder: default frame width and FSM states.
package manchester_led_encoder_pkg;
  localparam int FRAME_SIZE_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_GAP      = 3'd4
  } state_t;
endpackage

// File: rtl/manchester_led_encoder_if.sv
// Host-side frame write bus plus LED/status outputs of the Manchester LED encoder.
interface manchester_led_encoder_if
  import manchester_led_encoder_pkg::*;
#(
  parameter int FRAME_SIZE = FRAME_SIZE_DEF
);
  logic                  enable;
  logic [FRAME_SIZE-1:0] data;
  logic                  write;
  logic                  full;
  logic                  empty;
  logic                  busy;
  logic                  led;
  logic                  irq;

  modport master (output enable, data, write, input full, empty, busy, led, irq);
  modport slave  (input enable, data, write, output full, empty, busy, led, irq);
endinterface

// File: rtl/led_frame_fifo.sv
// Synchronous frame FIFO with registered full/empty; writes when full are dropped.
module led_frame_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rd_dat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             wr_acc, rd_acc;

  assign wr_acc   = wr_i && !full_q;
  assign rd_acc   = rd_i && !empty_q;
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign full_o   = full_q;
  assign empty_o  = empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_acc && !rd_acc)      cnt_d = cnt_q + 1'b1;
    else if (!wr_acc && rd_acc) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  // Pointers are AW bits wide, so the power-of-two depth makes them wrap on their own.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (AW+1)'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end
endmodule

// File: rtl/manchester_led_encoder.sv
// Queues frames, prepends a preamble and Manchester-codes them onto led; irq once per frame.
// Define LIGHTIO_PARITY_EN to append an even-parity symbol after the payload.
module manchester_led_encoder
  import manchester_led_encoder_pkg::*;
#(
  parameter int                       FRAME_SIZE    = FRAME_SIZE_DEF,
  parameter int                       HALF_PERIOD   = 4,
  parameter int                       PREAMBLE_BITS = 8,
  parameter logic [PREAMBLE_BITS-1:0] PREAMBLE      = 8'b1010_1011,
  parameter int                       GAP_CYCLES    = 8,
  parameter int                       FIFO_DEPTH    = 4
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  manchester_led_encoder_if.slave bus
);
  localparam int SW = PREAMBLE_BITS + FRAME_SIZE;
  localparam int CW = $clog2(SW + 1);
  localparam int HW = $clog2(HALF_PERIOD + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t                state_q;
  logic [SW-1:0]         shreg_q;
  logic [CW-1:0]         sym_cnt_q;
  logic [HW-1:0]         half_cnt_q;
  logic                  phase_q;
  logic [GW-1:0]         gap_cnt_q;
  logic                  led_q, irq_q, busy_q;
`ifdef LIGHTIO_PARITY_EN
  logic                  par_q;
`endif
  logic                  pop, sym_bit, half_end, fifo_empty;
  logic [FRAME_SIZE-1:0] fifo_dat;

  led_frame_fifo #(.WIDTH(FRAME_SIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wr_i     (bus.write),
    .wr_dat_i (bus.data),
    .rd_i     (pop),
    .rd_dat_o (fifo_dat),
    .full_o   (bus.full),
    .empty_o  (fifo_empty)
  );

  assign bus.empty = fifo_empty;
  assign bus.led   = led_q;
  assign bus.irq   = irq_q;
  assign bus.busy  = busy_q;

  always_comb begin
    pop      = (state_q == ST_IDLE) && bus.enable && !fifo_empty;
    half_end = (half_cnt_q == HW'(HALF_PERIOD - 1));
    sym_bit  = shreg_q[SW-1];
`ifdef LIGHTIO_PARITY_EN
    if (state_q == ST_PARITY) sym_bit = par_q;
`endif
  end

  // Outputs are registered from the current state, so led/irq/busy trail the FSM by one clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      sym_cnt_q  <= '0;
      half_cnt_q <= '0;
      phase_q    <= 1'b0;
      gap_cnt_q  <= '0;
      led_q      <= 1'b0;
      irq_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef LIGHTIO_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      led_q  <= 1'b0;
      irq_q  <= 1'b0;
      busy_q <= (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            shreg_q    <= {PREAMBLE, fifo_dat};
            sym_cnt_q  <= '0;
            half_cnt_q <= '0;
            phase_q    <= 1'b0;
`ifdef LIGHTIO_PARITY_EN
            par_q      <= ^fifo_dat;
`endif
            state_q    <= ST_PREAMBLE;
          end
        end
        ST_PREAMBLE, ST_DATA, ST_PARITY: begin
          led_q <= sym_bit ^ phase_q;
          if (half_end) begin
            half_cnt_q <= '0;
            phase_q    <= ~phase_q;
          end else begin
            half_cnt_q <= half_cnt_q + 1'b1;
          end
          if (half_end && phase_q) begin
            shreg_q   <= {shreg_q[SW-2:0], 1'b0};
            sym_cnt_q <= sym_cnt_q + 1'b1;
            if (state_q == ST_PREAMBLE && sym_cnt_q == CW'(PREAMBLE_BITS - 1)) begin
              sym_cnt_q <= '0;
              state_q   <= ST_DATA;
            end else if (state_q == ST_DATA && sym_cnt_q == CW'(FRAME_SIZE - 1)) begin
`ifdef LIGHTIO_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_GAP;
`endif
            end else if (state_q == ST_PARITY) begin
              state_q <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          irq_q <= (gap_cnt_q == '0);
          if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
            gap_cnt_q <= '0;
            state_q   <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_manchester_led_encoder.sv
// Randomized bench for manchester_led_encoder; led/irq/busy are compared every cycle with a timeline model.
module tb_manchester_led_encoder;
  localparam int HP  = 1;
  localparam int GAP = 8;
  localparam int FS  = 16;
  localparam int PB  = 8;
`ifdef LIGHTIO_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int NSYM = PB + FS + NPAR;
  localparam int L    = 2 * HP * NSYM;
  localparam int PER  = L + GAP + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_bad = 0;
  logic [PB-1:0] pre_v = 8'b1010_1011;
  logic [FS-1:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  manchester_led_encoder_if #(.FRAME_SIZE(FS)) bus ();

  manchester_led_encoder #(
    .FRAME_SIZE(FS), .HALF_PERIOD(HP), .PREAMBLE_BITS(PB),
    .PREAMBLE(8'b1010_1011), .GAP_CYCLES(GAP), .FIFO_DEPTH(4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Coded level at offset o (clocks) from the first preamble half-bit.
  function automatic logic coded(input logic [FS-1:0] d, input int o);
    int   sym  = o / (2 * HP);
    int   half = (o / HP) % 2;
    logic b;
    if (sym < PB)           b = pre_v[PB-1-sym];
    else if (sym < PB + FS) b = d[FS-1-(sym-PB)];
    else                    b = ^d;
    return (half != 0) ? ~b : b;
  endfunction

  // Frames in exp_q are popped back to back starting at edge p; check every cycle until edge fin.
  task automatic check_stream(input int p, input int fin);
    while (cyc < fin) begin
      logic e_led, e_irq, e_busy;
      @(negedge clk);
      e_led = 1'b0; e_irq = 1'b0; e_busy = 1'b0;
      for (int k = 0; k < exp_q.size(); k++) begin
        int o = cyc - (p + 1 + k * PER);
        if (o >= 0 && o < PER) begin
          if (o < L) e_led = coded(exp_q[k], o);
          e_irq  = (o == L);
          e_busy = (o < L + GAP);
        end
      end
      chk("led",  bus.led,  e_led);
      chk("irq",  bus.irq,  e_irq);
      chk("busy", bus.busy, e_busy);
    end
  endtask

  function automatic int stream_end(input int p);
    return p + 1 + exp_q.size() * PER + 3;
  endfunction

  task automatic wr_frame(input logic [FS-1:0] d);
    bus.data  = d;
    bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    bus.data  = FS'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    logic [FS-1:0] d, f0, f1;
    bus.enable = 1'b0;
    bus.write  = 1'b0;
    bus.data   = '0;
    repeat (3) @(negedge clk);
    chk("rst_led",   bus.led,   1'b0);
    chk("rst_irq",   bus.irq,   1'b0);
    chk("rst_busy",  bus.busy,  1'b0);
    chk("rst_full",  bus.full,  1'b0);
    chk("rst_empty", bus.empty, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single known frame.
    bus.enable = 1'b1;
    exp_q = {};
    exp_q.push_back(16'b0100_1111_1011_0110);
    p = cyc + 2;
    fork
      wr_frame(16'b0100_1111_1011_0110);
      check_stream(p, stream_end(p));
    join

    // Back-to-back all-ones then all-zeros.
    exp_q = {};
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    p = cyc + 2;
    fork
      begin wr_frame(16'hFFFF); wr_frame(16'h0000); end
      check_stream(p, stream_end(p));
    join

    // Random bursts written on consecutive cycles.
    for (int it = 0; it < 4; it++) begin
      int n = $urandom_range(1, 4);
      exp_q = {};
      for (int i = 0; i < n; i++) exp_q.push_back(FS'($urandom));
      p = cyc + 2;
      fork
        begin
          for (int i = 0; i < n; i++) wr_frame(exp_q[i]);
        end
        check_stream(p, stream_end(p));
      join
    end

    // Fill the FIFO with enable low; the fifth write must be dropped.
    bus.enable = 1'b0;
    exp_q = {};
    for (int i = 0; i < 5; i++) begin
      d = FS'($urandom);
      if (i < 4) exp_q.push_back(d);
      wr_frame(d);
      chk("fill_empty", bus.empty, 1'b0);
      chk("fill_full",  bus.full,  (i >= 3) ? 1'b1 : 1'b0);
    end
    repeat (3) @(negedge clk);
    chk("hold_busy", bus.busy, 1'b0);
    bus.enable = 1'b1;
    p = cyc + 1;
    check_stream(p, stream_end(p));
    chk("drain_empty", bus.empty, 1'b1);
    chk("drain_full",  bus.full,  1'b0);

    // Enable dropped during the preamble of the first of two queued frames.
    f0 = FS'($urandom);
    f1 = FS'($urandom);
    exp_q = {};
    exp_q.push_back(f0);
    p = cyc + 2;
    fork
      begin
        wr_frame(f0);
        wr_frame(f1);
        repeat (3) @(negedge clk);
        bus.enable = 1'b0;
      end
      check_stream(p, stream_end(p) + 10);
    join
    chk("endrop_empty", bus.empty, 1'b0);
    chk("endrop_busy",  bus.busy,  1'b0);
    bus.enable = 1'b1;
    exp_q = {};
    exp_q.push_back(f1);
    p = cyc + 1;
    check_stream(p, stream_end(p));
    chk("endrop_drain", bus.empty, 1'b1);

    // Reset during data bit 5; nothing may follow until a new frame is written.
    d = FS'($urandom);
    exp_q = {};
    exp_q.push_back(d);
    p = cyc + 2;
    fork
      wr_frame(d);
      check_stream(p, p + 1 + 2 * HP * (PB + 5));
    join
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_led",   bus.led,   1'b0);
    chk("mid_rst_busy",  bus.busy,  1'b0);
    chk("mid_rst_empty", bus.empty, 1'b1);
    chk("mid_rst_irq",   bus.irq,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q = {};
    check_stream(cyc, cyc + PER + 5);
    d = FS'($urandom);
    exp_q.push_back(d);
    p = cyc + 2;
    fork
      wr_frame(d);
      check_stream(p, stream_end(p));
    join
    chk("post_rst_empty", bus.empty, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/manchester_led_encoder.md
Name: manchester_led_encoder

Overview:
- Parametrised successor to the single-frame LED encoder.
- Accepts FRAME_SIZE-bit frames into a small FIFO, prepends a fixed preamble, and Manchester-codes each frame onto the LED output.
- Raises irq once per transmitted frame.
- Sits between the host-side frame source and the LED driver pad in the LightIO transmit path.

Parameters:
- FRAME_SIZE, 16, payload bits per frame, sent MSB first.
- HALF_PERIOD, 4, clocks per Manchester half-bit (>=1).
- PREAMBLE_BITS, 8, preamble length in bits.
- PREAMBLE, 8'b1010_1011, preamble pattern, sent MSB first, Manchester-coded like data.
- GAP_CYCLES, 8, clocks of LED low after each frame (>=1).
- FIFO_DEPTH, 4, frame buffer entries (power of two, >=2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  permits starting a new frame; does not abort one in flight.
- data  in  FRAME_SIZE  frame to enqueue.
- write  in  1  enqueue strobe; accepted when write && !full.
- full  out  1  FIFO full (registered).
- empty  out  1  FIFO empty (registered).
- busy  out  1  FSM not in IDLE.
- led  out  1  Manchester-coded optical output.
- irq  out  1  one-cycle pulse on frame completion.

Behaviour:
- Reset (reset==0, asynchronous): FSM=IDLE, FIFO emptied, all counters 0. Outputs: led=0, irq=0, busy=0, full=0, empty=1. Reset mid-frame aborts immediately; no irq is generated.
- Manchester coding: bit 1 = HALF_PERIOD clocks high, then HALF_PERIOD clocks low. Bit 0 = low, then high. Idle and gap level = 0.
- FSM states:
  - IDLE: if enable && !empty, pop the head entry into a shift register and go to PREAMBLE next edge.
  - PREAMBLE: shift out PREAMBLE_BITS symbols, then DATA.
  - DATA: shift out FRAME_SIZE symbols, then GAP.
  - GAP: led=0 for GAP_CYCLES clocks, then IDLE.
- irq: asserted for exactly one clock, the first cycle of GAP.
- Latency: write at edge N into an empty FIFO with FSM idle and enable=1 gives empty=0 after N; pop at N+1; first preamble half-bit on led from edge N+2.
- Frame length on led: 2*HALF_PERIOD*(PREAMBLE_BITS+FRAME_SIZE) clocks, then GAP_CYCLES.
- Back-to-back frames: IDLE lasts exactly one cycle between GAP end and the next PREAMBLE start.
- FIFO:
  - Pointers wrap modulo FIFO_DEPTH; the count is $clog2(FIFO_DEPTH)+1 bits.
  - Write when full: ignored, no state change.
  - Simultaneous write and pop: both take effect, count unchanged.
  - Pop occurs only from IDLE with !empty.
- enable deasserted during a frame: the frame and its gap complete, irq still fires, then the FSM holds in IDLE.
- data is sampled only on an accepted write; later changes do not affect queued frames.
- led and irq are driven directly from flops (no combinational output path).

Optional Feature:
- Macro: LIGHTIO_PARITY_EN.
- Defined: one even-parity symbol (XOR of the payload) is sent after the last data bit, before GAP. Frame length grows by 2*HALF_PERIOD clocks. irq timing moves accordingly.
- Undefined: no parity symbol; frame length as above.

Decomposition:
- Shared definitions file: FRAME_SIZE default and FSM state encodings (IDLE, PREAMBLE, DATA, PARITY, GAP) as localparam/`define constants.
- Sub-module led_frame_fifo (synchronous FIFO, FRAME_SIZE wide, FIFO_DEPTH deep) with full/empty flags.
- Encoder FSM, half-bit counter and shift register stay in the top.

Test Plan (HALF_PERIOD=1, GAP_CYCLES=8, parity off unless stated):
- Single frame: write data=16'b0100_1111_1011_0110 at edge N -> led starts 1,0 (preamble bit 1) at N+2. led carries 48 cycles of coded preamble+payload. irq pulses 1 cycle at N+50. busy falls at N+58.
- Back-to-back: write 16'hFFFF then 16'h0000 -> second frame's preamble starts 1 cycle after the first GAP ends. Two irq pulses 57 cycles apart. Payload halves are 1,0 repeated, then 0,1 repeated.
- FIFO full: enable=0, write 5 frames with FIFO_DEPTH=4 -> full=1 after the 4th; 5th ignored. Set enable=1 -> exactly 4 irq pulses, in write order.
- Reset mid-frame: pull reset low during DATA bit 5 -> led=0, busy=0, empty=1 immediately. No irq. Next written frame transmits cleanly.
- Enable drop: deassert enable during PREAMBLE with 2 frames queued -> current frame completes with irq. FSM stays IDLE with empty=0 until enable=1.
- Parity (LIGHTIO_PARITY_EN): data=16'h0001 -> parity symbol 1 (led 1,0) after payload. irq at N+52.
